// File: rtl/ps2_key_event_rx.sv
// rtl/ps2_key_event_rx.sv - PS/2 keyboard receiver with glitch filter, prefix decoder and event FIFO
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   ev_valid/ev_ready   FWFT event FIFO head handshake
//   ev_code/ev_ext/ev_break  head event: scan code, E0 prefix, release
//   fifo_level          entries currently queued
//   raw_valid/raw_byte  one-cycle pulse per good byte, last good byte
//   err_parity/err_frame/overflow  sticky error flags
//   err_clear           one-cycle pulse clearing the sticky flags
module ps2_key_event_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [LVL_W-1:0] fifo_level,
  output logic             raw_valid,
  output logic [7:0]       raw_byte,
  output logic             err_parity,
  output logic             err_frame,
  output logic             overflow,
  input  logic             err_clear
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = 5;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} dec_state_e;

  // Input conditioning
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic clk_f_q, clk_f_d;
  logic [FC_W-1:0] flt_cnt_q, flt_cnt_d;
  logic fall;

  // Frame receiver
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            start_bad_q, start_bad_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            raw_valid_q, raw_valid_d;
  logic [7:0]      raw_byte_q, raw_byte_d;
  logic            set_par, set_frm;

  // Decoder
  dec_state_e st_q, st_d;
  logic [2:0] skip_q, skip_d;
  logic       push_q, push_d;
  logic [9:0] push_ev_q, push_ev_d;   // {ext, brk, code}

  // FIFO
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop, full, wr_en, ovf_set;

  // Sticky flags
  logic err_parity_q, err_frame_q, overflow_q;

  function automatic logic is_drop(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE) ||
           (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_f_d   = clk_f_q;
    flt_cnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (flt_cnt_q == FC_W'(FILTER_LEN - 1)) clk_f_d = ~clk_f_q;
      else                                    flt_cnt_d = flt_cnt_q + FC_W'(1);
    end
  end

  assign fall = clk_f_q & ~clk_f_d;

  always_comb begin
    idx_d       = idx_q;
    shift_d     = shift_q;
    start_bad_d = start_bad_q;
    par_d       = par_q;
    to_d        = '0;
    raw_valid_d = 1'b0;
    raw_byte_d  = raw_byte_q;
    set_par     = 1'b0;
    set_frm     = 1'b0;
    if (fall) begin
      if (idx_q == 4'd0) begin
        start_bad_d = dat_s2_q;
        par_d       = 1'b0;
        idx_d       = 4'd1;
      end else if (idx_q <= 4'd8) begin
        shift_d = {dat_s2_q, shift_q[7:1]};
        par_d   = par_q ^ dat_s2_q;
        idx_d   = idx_q + 4'd1;
      end else if (idx_q == 4'd9) begin
        par_d = par_q ^ dat_s2_q;
        idx_d = 4'd10;
      end else begin
        idx_d = 4'd0;
        // Framing faults take priority over parity when both are wrong.
        if (start_bad_q || !dat_s2_q) begin
          set_frm = 1'b1;
        end else if (!par_q) begin
          set_par = 1'b1;
        end else begin
          raw_valid_d = 1'b1;
          raw_byte_d  = shift_q;
        end
      end
    end else if (idx_q != 4'd0) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        idx_d   = 4'd0;
        set_frm = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    skip_d    = skip_q;
    push_d    = 1'b0;
    push_ev_d = push_ev_q;
    if (raw_valid_q) begin
      case (st_q)
        S_IDLE: begin
          if (raw_byte_q == 8'hE0)      st_d = S_EXT;
          else if (raw_byte_q == 8'hF0) st_d = S_BRK;
          else if (raw_byte_q == 8'hE1) begin
            st_d   = S_PAUSE;
            skip_d = 3'd7;
          end else if (!is_drop(raw_byte_q)) begin
            push_d    = 1'b1;
            push_ev_d = {2'b00, raw_byte_q};
          end
        end
        S_EXT: begin
          if (raw_byte_q == 8'hF0) begin
            st_d = S_EXTBRK;
          end else begin
            st_d = S_IDLE;
            if (!is_drop(raw_byte_q) && !is_fake_shift(raw_byte_q) &&
                raw_byte_q != 8'hE0 && raw_byte_q != 8'hE1) begin
              push_d    = 1'b1;
              push_ev_d = {2'b10, raw_byte_q};
            end
          end
        end
        S_BRK: begin
          st_d      = S_IDLE;
          push_d    = 1'b1;
          push_ev_d = {2'b01, raw_byte_q};
        end
        S_EXTBRK: begin
          st_d = S_IDLE;
          if (!is_fake_shift(raw_byte_q)) begin
            push_d    = 1'b1;
            push_ev_d = {2'b11, raw_byte_q};
          end
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            st_d      = S_IDLE;
            push_d    = 1'b1;
            push_ev_d = {2'b00, 8'hE1};
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  assign ev_valid = (level_q != '0);
  assign pop      = ev_valid & ev_ready;
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = push_q & (~full | pop);
  assign ovf_set  = push_q & full & ~pop;

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
    else if (!wr_en && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_ev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      flt_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      start_bad_q  <= 1'b0;
      par_q        <= 1'b0;
      to_q         <= '0;
      raw_valid_q  <= 1'b0;
      raw_byte_q   <= '0;
      st_q         <= S_IDLE;
      skip_q       <= '0;
      push_q       <= 1'b0;
      push_ev_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      clk_f_q      <= clk_f_d;
      flt_cnt_q    <= flt_cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      start_bad_q  <= start_bad_d;
      par_q        <= par_d;
      to_q         <= to_d;
      raw_valid_q  <= raw_valid_d;
      raw_byte_q   <= raw_byte_d;
      st_q         <= st_d;
      skip_q       <= skip_d;
      push_q       <= push_d;
      push_ev_q    <= push_ev_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q      <= level_d;
      // Set wins over a simultaneous clear.
      err_parity_q <= (err_parity_q & ~err_clear) | set_par;
      err_frame_q  <= (err_frame_q & ~err_clear) | set_frm;
      overflow_q   <= (overflow_q & ~err_clear) | ovf_set;
    end
  end

  // Head fields are masked while empty so the unreset memory never shows.
  assign ev_code    = ev_valid ? mem[rd_ptr_q][7:0] : 8'h00;
  assign ev_ext     = ev_valid & mem[rd_ptr_q][9];
  assign ev_break   = ev_valid & mem[rd_ptr_q][8];
  assign fifo_level = level_q;
  assign raw_valid  = raw_valid_q;
  assign raw_byte   = raw_byte_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb/tb_ps2_key_event_rx.sv - directed self-checking bench for ps2_key_event_rx
module tb_ps2_key_event_rx;
  localparam int FILTER_LEN = 8;
  localparam int DEPTH      = 8;
  localparam int TIMEOUT    = 300;
  localparam int LVL_W      = $clog2(DEPTH) + 1;
  localparam int HALF       = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_break;
  logic [LVL_W-1:0] fifo_level;
  logic             raw_valid;
  logic [7:0]       raw_byte;
  logic             err_parity;
  logic             err_frame;
  logic             overflow;
  logic             err_clear = 1'b0;

  int checks   = 0;
  int failures = 0;
  int raw_cnt  = 0;
  int cnt0;

  ps2_key_event_rx #(
    .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .fifo_level(fifo_level),
    .raw_valid(raw_valid), .raw_byte(raw_byte), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && raw_valid) raw_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(HALF);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check(tag, {ev_ext, ev_break, ev_code}, exp);
    ev_ready = 1'b1;
    cycles(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_ev_valid", ev_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_raw", {raw_valid, raw_byte}, 0);
    check("rst_errs", {err_parity, err_frame, overflow}, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);

    // Plain make code
    send_frame(8'h1C, 1'b0);
    cycles(5);
    check("a_raw_cnt", raw_cnt, 1);
    check("a_raw_byte", raw_byte, 8'h1C);
    check("a_ev_valid", ev_valid, 1);
    check("a_level", fifo_level, 1);
    pop_check("a_head", 10'h01C);
    check("a_level_after_pop", fifo_level, 0);
    check("a_ev_valid_after_pop", ev_valid, 0);

    // Extended break: E0 F0 75
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("ext_prefix_level", fifo_level, 0);
    send_frame(8'h75, 1'b0);
    cycles(5);
    check("ext_raw_cnt", raw_cnt, 4);
    check("ext_level", fifo_level, 1);
    pop_check("ext_head", 10'h375);

    // Parity error
    send_frame(8'h1C, 1'b1);
    cycles(5);
    check("par_err", err_parity, 1);
    check("par_raw_cnt", raw_cnt, 4);
    check("par_level", fifo_level, 0);
    check("par_no_frame_err", err_frame, 0);
    pulse_clear();
    check("par_cleared", err_parity, 0);

    // Stalled frame and timeout recovery
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
      cycles(HALF);
    end
    cycles(TIMEOUT + 100);
    check("to_frame_err", err_frame, 1);
    send_frame(8'h29, 1'b0);
    cycles(5);
    check("to_raw_byte", raw_byte, 8'h29);
    check("to_level", fifo_level, 1);
    pop_check("to_head", 10'h029);
    pulse_clear();
    check("to_cleared", err_frame, 0);

    // Overflow: DEPTH+1 makes with consumer stalled
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0);
    cycles(5);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_flag", overflow, 1);
    pulse_clear();
    check("ovf_cleared", overflow, 0);

    // Simultaneous pop and push while full
    cnt0 = raw_cnt;
    fork
      send_frame(8'h20, 1'b0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!raw_valid && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check("swap_wait_timeout", (n < 3000), 1);
        @(posedge clk);
        #1 ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
      end
    join
    cycles(5);
    check("swap_raw_cnt", raw_cnt - cnt0, 1);
    check("swap_level", fifo_level, DEPTH);
    check("swap_no_ovf", overflow, 0);
    for (int i = 1; i < DEPTH; i++) pop_check("drain_order", {2'b00, 8'h10 + 8'(i)});
    pop_check("drain_last", 10'h020);
    check("drain_empty", fifo_level, 0);

    // Short glitches on ps2_clk must not start a frame
    cnt0 = raw_cnt;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      cycles(3);
      ps2_clk = 1'b1;
      cycles(10);
    end
    cycles(TIMEOUT + 100);
    check("glitch_no_frame_err", err_frame, 0);
    check("glitch_no_raw", raw_cnt - cnt0, 0);

    // Pause sequence collapses into one event
    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("pause_pending_level", fifo_level, 0);
    send_frame(8'h77, 1'b0);
    cycles(5);
    check("pause_level", fifo_level, 1);
    pop_check("pause_head", 10'h0E1);

    // Reset asserted mid-frame with state present
    send_frame(8'h1C, 1'b1);
    send_frame(8'h33, 1'b0);
    cycles(5);
    check("pre_rst_level", fifo_level, 1);
    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
      cycles(HALF);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_fifo", {ev_valid, fifo_level}, 0);
    check("mid_rst_head", {ev_ext, ev_break, ev_code}, 0);
    check("mid_rst_raw", {raw_valid, raw_byte}, 0);
    check("mid_rst_errs", {err_parity, err_frame, overflow}, 0);
    ps2_data = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised second-generation PS/2 keyboard receiver. It oversamples ps2_clk/ps2_data on the system clock with a configurable glitch filter and checks start, parity and stop bits. It recovers from stalled frames with a timeout, decodes E0/F0/E1 prefix sequences into single key events, and queues those events in a FIFO with a valid/ready handshake. It sits between the PS/2 pins and the key-mapping and CPU I/O logic, and replaces the fixed 3-byte history scheme.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised samples needed before the filtered ps2_clk changes level (range 2..16).
FIFO_DEPTH, 8, event FIFO entries; must be a power of two, range 2..64.
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge, mid-frame, before the frame is abandoned.
LVL_W, $clog2(FIFO_DEPTH)+1, derived width of fifo_level; do not override.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head when ev_valid is high
ev_code  out  8  scan code of head event
ev_ext  out  1  head event had an E0 prefix
ev_break  out  1  head event is a release
fifo_level  out  LVL_W  entries currently queued
raw_valid  out  1  one-cycle pulse: a good byte was received
raw_byte  out  8  last good byte; held between pulses
err_parity  out  1  sticky: parity error seen
err_frame  out  1  sticky: bad start/stop bit or timeout
overflow  out  1  sticky: event dropped because the FIFO was full
err_clear  in  1  one-cycle pulse; clears the three sticky flags

Behaviour:
- Reset (async, rst_n=0): all outputs are 0. Filter state and synchroniser outputs are 1 (idle bus). FIFO is empty, decoder is IDLE, bit counter is 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - A filter counter tracks the synchronised clock. Filtered clk flips after FILTER_LEN consecutive samples differing from its current value; any mismatch resets the counter.
  - A falling edge is the cycle the filtered clk goes 1->0. Synchronised data is sampled in that cycle.
- Frame receiver. Bit index 0..10, advanced on each falling edge:
  - idx 0: start bit; must be 0.
  - idx 1..8: data bits, LSB first.
  - idx 9: parity; data plus parity must hold an odd number of ones.
  - idx 10: stop bit; must be 1.
  - At idx 10 the frame resolves. Good frame: raw_byte is updated and raw_valid pulses the next cycle. Parity fail: set err_parity, byte discarded. Start or stop fail: set err_frame, byte discarded. idx returns to 0 in all cases.
  - Timeout: when idx is not 0, a counter counts cycles since the last falling edge. When it reaches TIMEOUT_CYCLES: idx goes to 0, err_frame is set, the partial byte is discarded, and the decoder is unaffected.
- Decoder FSM, advanced only on raw_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip=7); AA/FA/EE/FE/FC/00/FF are dropped and stay IDLE; any other byte b pushes {ext=0, brk=0, b}.
  - EXT: F0 -> EXTBRK; E0/F0-class codes -> IDLE with nothing pushed; other b pushes {1,0,b} -> IDLE.
  - BRK: b pushes {0,1,b} -> IDLE.
  - EXTBRK: b pushes {1,1,b} -> IDLE.
  - PAUSE: each byte decrements skip. When skip reaches 0, push {0,0,E1} -> IDLE.
  - Fake-shift codes: E0 12 and E0 59 (make or break) are dropped.
- FIFO:
  - First-word-fall-through. A push into an empty FIFO makes ev_valid high the next cycle, with ev_* presenting the head.
  - Pop happens when ev_valid && ev_ready. Push happens the cycle after raw_valid for event-producing bytes.
  - Push and pop in the same cycle: both take effect and level is unchanged. This includes the full case, where the push is accepted and overflow is not set.
  - Push when full with no pop: the event is dropped and overflow is set.
  - fifo_level is registered and updated the same edge as the pointers. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: err_clear clears them. If err_clear and a new error occur in the same cycle, the flag reads 1 afterwards (set wins).

Test Plan:
- Send make 0x1C (A) with correct parity -> raw_valid pulse with raw_byte=0x1C; ev_valid rises; head={ext0, brk0, 1C}; ready=1 pops and level goes 1->0.
- Send E0 F0 75 (up-arrow release) -> exactly one event {ext1, brk1, 75}; fifo_level=1; nothing pushed for the prefix bytes.
- Send 0x1C with parity forced wrong -> err_parity=1, no raw_valid, fifo_level=0. Pulse err_clear -> err_parity=0.
- Pull ps2_clk low and high 5 times, then hold it idle for more than TIMEOUT_CYCLES -> err_frame=1, idx=0. The next clean 0x29 frame is received correctly.
- Hold ev_ready=0 and send FIFO_DEPTH+1 makes -> level=FIFO_DEPTH, overflow=1, first FIFO_DEPTH codes retained in order. Then pop and push in the same cycle while full -> level stays FIFO_DEPTH and overflow is not newly set.
- With 3-cycle glitches (shorter than FILTER_LEN) on ps2_clk during idle -> no bit activity. Send E1 14 77 E1 F0 14 F0 77 -> single event {0, 0, E1}. Assert rst_n=0 mid-frame -> all outputs 0 immediately and FIFO empty.
